// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deglitched clock, 11-bit frame check, E0/F0 prefix folding, FWFT code FIFO.
// A code is written one cycle after the stop-bit edge; when code_ready is low the FIFO fills and excess codes are dropped.

module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_vld,
  input  logic [W-1:0]               in_dat,
  output logic                       out_vld,
  output logic [W-1:0]               out_dat,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, push, pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop     = !empty && out_rdy;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push    = in_vld && (!full || pop);
  assign drop    = in_vld && full && !pop;
  assign out_vld = !empty;
  assign out_dat = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                            clock,
  input  logic                            reset_neg,
  input  logic                            PS2_clock,
  input  logic                            PS2_data,
  output logic [7:0]                      code_data,
  output logic                            code_extended,
  output logic                            code_break,
  output logic                            code_valid,
  input  logic                            code_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            busy,
  output logic                            parity_error,
  output logic                            framing_error,
  output logic                            timeout_error,
  output logic                            overflow_drop
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RX, CHECK} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } code_t;

  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  fclk_q, fclk_d;
  logic                  fall;
  state_t                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [9:0]            shift_q, shift_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  ext_q, ext_d, brk_q, brk_d;
  logic                  frm_err, par_err, to_err, byte_vld, push;
  code_t                 push_dat, head;

  // Filtered clock only moves once the whole window agrees.
  always_comb begin
    filt_d = {PS2_clock, filt_q[FILTER_LEN-1:1]};
    fclk_d = fclk_q;
    if (&filt_q)       fclk_d = 1'b1;
    else if (~|filt_q) fclk_d = 1'b0;
  end

  assign fall = fclk_q && ~|filt_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = to_cnt_q;
    frm_err   = 1'b0;
    par_err   = 1'b0;
    to_err    = 1'b0;
    byte_vld  = 1'b0;
    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (fall) begin
          if (!PS2_data) begin
            state_d   = RX;
            bit_cnt_d = '0;
          end else begin
            frm_err = 1'b1;
          end
        end
      end
      RX: begin
        if (fall) begin
          shift_d   = {PS2_data, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          to_cnt_d  = '0;
          if (bit_cnt_q == 4'd9) state_d = CHECK;
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
          to_err  = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        // shift_q holds {stop, parity, data[7:0]}; a bad stop outranks bad parity.
        state_d = IDLE;
        if (!shift_q[9])          frm_err  = 1'b1;
        else if (!(^shift_q[8:0])) par_err  = 1'b1;
        else                       byte_vld = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    push     = 1'b0;
    push_dat = '{ext: ext_q, brk: brk_q, code: shift_q[7:0]};
    if (frm_err || par_err || to_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld) begin
      if (shift_q[7:0] == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q[7:0] == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      filt_q    <= '1;
      fclk_q    <= 1'b1;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      to_cnt_q  <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      filt_q    <= filt_d;
      fclk_q    <= fclk_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      to_cnt_q  <= to_cnt_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
    end
  end

  fifo #(
    .W     (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset_neg),
    .in_vld  (push),
    .in_dat  (push_dat),
    .out_vld (code_valid),
    .out_dat (head),
    .out_rdy (code_ready),
    .count   (fifo_count),
    .drop    (overflow_drop)
  );

  assign code_data     = head.code;
  assign code_extended = head.ext;
  assign code_break    = head.brk;
  assign busy          = (state_q != IDLE);
  assign parity_error  = par_err;
  assign framing_error = frm_err;
  assign timeout_error = to_err;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: directed and random PS/2 frames scored against a frame-level model.
// The model tracks prefix flags, expected FIFO contents and expected error pulse counts.

module tb_ps2_scancode_rx;
  localparam int FL    = 8;
  localparam int TO    = 5000;
  localparam int DEPTH = 8;
  localparam int HALF  = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset_neg, PS2_clock, PS2_data, code_ready;
  logic [7:0]    code_data;
  logic          code_extended, code_break, code_valid, busy;
  logic [CW-1:0] fifo_count;
  logic          parity_error, framing_error, timeout_error, overflow_drop;

  ps2_scancode_rx #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock         (clock),
    .reset_neg     (reset_neg),
    .PS2_clock     (PS2_clock),
    .PS2_data      (PS2_data),
    .code_data     (code_data),
    .code_extended (code_extended),
    .code_break    (code_break),
    .code_valid    (code_valid),
    .code_ready    (code_ready),
    .fifo_count    (fifo_count),
    .busy          (busy),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .timeout_error (timeout_error),
    .overflow_drop (overflow_drop)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observed side: pulse-cycle counts and every popped entry as {ext, brk, code}.
  int         par_cnt = 0, frm_cnt = 0, to_cnt = 0, ovf_cnt = 0, popped = 0;
  logic [9:0] got_q[$];

  always @(negedge clock) begin
    if (reset_neg) begin
      if (parity_error)  par_cnt++;
      if (framing_error) frm_cnt++;
      if (timeout_error) to_cnt++;
      if (overflow_drop) ovf_cnt++;
      if (code_valid && code_ready) begin
        got_q.push_back({code_extended, code_break, code_data});
        popped++;
      end
    end
  end

  // Reference side.
  int         e_par = 0, e_frm = 0, e_to = 0, e_ovf = 0, pushed = 0;
  bit         m_ext = 0, m_brk = 0;
  logic [9:0] exp_q[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int occ;
    if (bad_stop) begin
      e_frm++; m_ext = 0; m_brk = 0;
    end else if (bad_par) begin
      e_par++; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      // With the consumer ready, everything earlier has drained before this code lands.
      occ = code_ready ? 0 : pushed - popped;
      if (occ < DEPTH) begin
        exp_q.push_back({m_ext, m_brk, b});
        pushed++;
      end else begin
        e_ovf++;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_data = bits[i];
      tick(HALF / 2);
      if (i == glitch_bit) begin
        PS2_clock = 1'b0;
        tick(3);
        PS2_clock = 1'b1;
        tick(HALF / 2);
      end
      PS2_clock = 1'b0;
      tick(HALF);
      PS2_clock = 1'b1;
      tick(HALF / 2);
    end
    PS2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    model_frame(b, bad_par, bad_stop);
    send_frame(b, bad_par, bad_stop, 11, -1);
  endtask

  task automatic checkpoint(input string tag);
    tick(4);
    while (got_q.size() > 0) begin
      if (exp_q.size() == 0) chk({tag, " unexpected_pop"}, {22'd0, got_q.pop_front()}, 32'hFFFF_FFFF);
      else                   chk({tag, " entry"}, {22'd0, got_q.pop_front()}, {22'd0, exp_q.pop_front()});
    end
    chk({tag, " fifo_count"}, fifo_count, pushed - popped);
    chk({tag, " parity_pulses"}, par_cnt, e_par);
    chk({tag, " framing_pulses"}, frm_cnt, e_frm);
    chk({tag, " timeout_pulses"}, to_cnt, e_to);
    chk({tag, " overflow_pulses"}, ovf_cnt, e_ovf);
    chk({tag, " busy"}, busy, 0);
    if (pushed == popped) chk({tag, " empty_head"}, {code_valid, code_extended, code_break, code_data}, 0);
    else if (exp_q.size() > 0) chk({tag, " head"}, {code_extended, code_break, code_data}, exp_q[0]);
  endtask

  logic [7:0] ovf_codes [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  initial begin
    reset_neg  = 1'b0;
    PS2_clock  = 1'b1;
    PS2_data   = 1'b1;
    code_ready = 1'b1;
    #2;
    chk("reset outputs", {code_valid, code_extended, code_break, code_data, busy,
                          parity_error, framing_error, timeout_error, overflow_drop}, 0);
    chk("reset fifo_count", fifo_count, 0);
    #20 reset_neg = 1'b1;
    tick(3);

    do_frame(8'h1C, 0, 0);
    checkpoint("single_1c");

    do_frame(8'hE0, 0, 0);
    do_frame(8'hF0, 0, 0);
    do_frame(8'h75, 0, 0);
    checkpoint("e0_f0_75");
    do_frame(8'h75, 0, 0);
    checkpoint("plain_75");

    do_frame(8'hE0, 0, 0);
    do_frame(8'h1C, 1, 0);
    do_frame(8'hF0, 0, 0);
    do_frame(8'h1C, 0, 0);
    checkpoint("parity_clears");
    do_frame(8'h1C, 1, 1);
    checkpoint("stop_bad");

    do_frame(8'hF0, 0, 0);
    send_frame(8'h45, 0, 0, 5, -1);
    chk("busy_partial", busy, 1);
    e_to++; m_ext = 0; m_brk = 0;
    tick(TO + 100);
    checkpoint("timeout");
    do_frame(8'h45, 0, 0);
    checkpoint("after_timeout");

    code_ready = 1'b0;
    foreach (ovf_codes[i]) do_frame(ovf_codes[i], 0, 0);
    checkpoint("overflow_full");
    code_ready = 1'b1;
    checkpoint("overflow_drain");

    PS2_clock = 1'b0;
    tick(3);
    PS2_clock = 1'b1;
    tick(HALF);
    model_frame(8'h2C, 0, 0);
    send_frame(8'h2C, 0, 0, 11, 4);
    checkpoint("glitch");

    code_ready = 1'b0;
    do_frame(8'h1C, 0, 0);
    checkpoint("pre_reset");
    send_frame(8'h33, 0, 0, 4, -1);
    reset_neg = 1'b0;
    #1;
    chk("midreset outputs", {code_valid, code_extended, code_break, code_data, busy,
                             parity_error, framing_error, timeout_error, overflow_drop}, 0);
    chk("midreset fifo_count", fifo_count, 0);
    tick(2);
    reset_neg = 1'b1;
    exp_q.delete();
    pushed = popped;
    m_ext = 0; m_brk = 0;
    code_ready = 1'b1;
    tick(2);
    do_frame(8'h5A, 0, 0);
    checkpoint("after_reset");

    for (int n = 0; n < 40; n++) begin
      int         kind;
      logic [7:0] b;
      code_ready = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 9);
      b    = 8'($urandom);
      case (kind)
        0:       do_frame(8'hE0, 0, 0);
        1:       do_frame(8'hF0, 0, 0);
        2:       do_frame(b, 1, 0);
        3:       do_frame(b, $urandom_range(0, 1) != 0, 1);
        default: do_frame(b, 0, 0);
      endcase
      if (n % 8 == 7) checkpoint("random");
    end
    code_ready = 1'b1;
    tick(20);
    checkpoint("random_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

Parametrised PS/2 keyboard receiver, successor to the single-byte, display-driving receiver. It filters the PS/2 clock and receives 11-bit frames. It checks start, odd parity and stop bits and aborts stalled frames on a timeout. It folds the E0 (extended) and F0 (break) prefixes into a tagged scan code and buffers the results in a FIFO with a valid/ready handshake for downstream logic (display, command decoder).

## Interface
- FILTER_LEN, 8, PS/2 clock deglitch shift-register length (≥2)
- TIMEOUT_CYCLES, 5000, max `clock` cycles between falling PS/2 edges inside a frame (100 µs at 50 MHz)
- FIFO_DEPTH, 8, scan-code FIFO entries (power of 2, ≥2)

- clock  in  1  system clock
- reset_neg  in  1  reset, asynchronous, active-low
- PS2_clock  in  1  raw PS/2 clock, asynchronous to `clock`
- PS2_data  in  1  raw PS/2 data
- code_data  out  8  scan code at FIFO head
- code_extended  out  1  head entry was preceded by E0
- code_break  out  1  head entry was preceded by F0 (key release)
- code_valid  out  1  FIFO non-empty
- code_ready  in  1  consumer accepts head entry
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries
- busy  out  1  frame FSM not in IDLE
- parity_error  out  1  one-cycle pulse, bad parity
- framing_error  out  1  one-cycle pulse, bad start or stop bit
- timeout_error  out  1  one-cycle pulse, frame stalled
- overflow_drop  out  1  one-cycle pulse, code lost to a full FIFO

## Operation
- Filter: shift register, `{PS2_clock, filt[FILTER_LEN-1:1]}`. The filtered clock goes to 1 when the register is all ones and to 0 when it is all zeros; otherwise it holds.
- `fall` is a one-cycle pulse in the cycle where the filtered clock goes 1→0. `PS2_data` is sampled in the `fall` cycle.
- Frame FSM states are IDLE, RX and CHECK.
  - IDLE: on `fall` with data=0, clear the bit counter and go to RX. On `fall` with data=1, pulse framing_error and stay in IDLE.
  - RX: each `fall` shifts data in LSB-first (8 data bits, parity, stop). The timeout counter clears on every `fall`. The 10th `fall` in RX goes to CHECK. If the timeout counter reaches TIMEOUT_CYCLES, pulse timeout_error, discard the partial frame and go to IDLE.
  - CHECK (1 cycle), then IDLE:
    - If stop=0: framing_error. This takes priority over parity.
    - Else if the XOR of the data bits and parity bit is 0: parity_error.
    - Else: the byte goes to the decoder.
- Decoder:
  - Byte E0 sets ext_pend.
  - Byte F0 sets brk_pend.
  - Any other byte pushes {ext_pend, brk_pend, byte} and clears both flags.
  - Any error pulse clears both flags.
- FIFO is first-word fall-through. The head is always visible on the code_* outputs. Pop when code_valid && code_ready.
  - Push into a full FIFO with no simultaneous pop: entry dropped, overflow_drop pulses, contents unchanged.
  - Full FIFO with simultaneous push and pop: both occur, count unchanged.
  - Empty FIFO: code_ready is ignored. code_data, code_extended and code_break are 0 while empty.
- Reset: asynchronous. Filter register all ones, filtered clock 1, FSM in IDLE, counters 0, flags 0, FIFO empty. Every output is 0. Reset mid-frame discards the frame and emits no error pulse.

## Timing
- Filter delay: a clean PS/2 edge produces `fall` in the FILTER_LEN-th clock cycle after the first low sample.
- A low or high pulse shorter than FILTER_LEN cycles never changes the filtered clock.
- The stop-bit `fall` in cycle T gives CHECK in T+1 and the FIFO write at the end of T+1. code_valid rises in T+2, and fifo_count updates in T+2.
- Error pulses are asserted in the CHECK cycle (T+1). timeout_error is asserted in the cycle the counter reaches TIMEOUT_CYCLES.
- A pop takes effect on the clock edge where valid&&ready. The next entry is visible the following cycle.
- Throughput: one code per frame. The FSM is back in IDLE before the next possible start edge.

## Test plan
- Frame 0x1C (parity 0, stop 1) with code_ready=1 → code_valid pulses one cycle, code_data=0x1C, ext=0, brk=0, fifo_count returns to 0.
- Frames E0, F0, 0x75 → exactly one entry: code_data=0x75, ext=1, brk=1. Then frame 0x75 alone → ext=0, brk=0.
- Frame 0x1C with parity bit 1 → parity_error pulse, FIFO unchanged. The following F0 then 0x1C → entry brk=1, proving the flags were cleared by the error. Frame with stop=0 → framing_error only.
- Stop the PS/2 clock after 5 bits and wait TIMEOUT_CYCLES → timeout_error pulse, busy drops. The next frame 0x45 is received intact.
- With code_ready=0, send FIFO_DEPTH+1 codes (0x16, 0x1E, …) → fifo_count=FIFO_DEPTH, one overflow_drop pulse. Draining returns the first FIFO_DEPTH codes in order.
- A 3-cycle low glitch on PS2_clock in IDLE and in RX → no `fall`, no bit counted, frame still decodes correctly. Assert reset_neg mid-frame → all outputs 0 immediately, and the next full frame decodes.
